// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op codes, FSM state encoding and default datapath width.
// Combinational constants only; no latency or backpressure of its own.
package mdu_ctrl_pkg;

    localparam int MDU_WIDTH_DEF = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mdu_ctrl_iter.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on a 2*WIDTH partial value.
// Purely combinational, zero latency; no flow control.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_p,
    input  logic [WIDTH-1:0]   i_d,
    input  logic               i_div,
    output logic [2*WIDTH-1:0] o_p
);

    logic [WIDTH:0]   w_acc;
    logic [WIDTH:0]   w_top;
    logic [WIDTH+1:0] w_diff;

    // Multiply: upper half accumulates (with carry), lower half holds the shrinking multiplier.
    // Divide: {remainder, dividend} shifts left; a non-borrowing trial subtract sets a quotient bit.
    always_comb begin
        w_acc  = i_p[0] ? ({1'b0, i_p[2*WIDTH-1:WIDTH]} + {1'b0, i_d})
                        : {1'b0, i_p[2*WIDTH-1:WIDTH]};
        w_top  = i_p[2*WIDTH-1:WIDTH-1];
        w_diff = {1'b0, w_top} - {2'b00, i_d};
        o_p    = {w_acc, i_p[WIDTH-1:1]};
        if (i_div) begin
            if (!w_diff[WIDTH+1]) begin
                o_p = {w_diff[WIDTH-1:0], i_p[WIDTH-2:0], 1'b1};
            end else begin
                o_p = {i_p[2*WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide unit: WIDTH-step iterative MULT/DIV, WIDTH+2 cycles start-to-done; MTHI/MTLO take one edge.
// Starts while busy are dropped (no queue); divider present only when MDU_DIV_EN is defined.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_dz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_d;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_is_div;
    logic               r_dz_pend;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
`ifdef MDU_DIV_EN
    logic [WIDTH-1:0]   r_a;
`endif

    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_div_mode;
    logic [2*WIDTH-1:0] w_iter;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_sa     = w_signed & i_a[WIDTH-1];
    assign w_sb     = w_signed & i_b[WIDTH-1];
    assign w_a_mag  = w_sa ? -i_a : i_a;
    assign w_b_mag  = w_sb ? -i_b : i_b;

`ifdef MDU_DIV_EN
    assign w_div_mode = (r_state == S_DIV);
`else
    assign w_div_mode = 1'b0;
`endif

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .i_p   (r_p),
        .i_d   (r_d),
        .i_div (w_div_mode),
        .o_p   (w_iter)
    );

    // Sign correction from the magnitude result; the most-negative / -1 case falls out naturally.
    assign w_prod_fix = r_neg_lo ? -r_p : r_p;
    assign w_q_fix    = r_neg_lo ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    assign w_r_fix    = r_neg_hi ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_p       <= '0;
            r_d       <= '0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_is_div  <= 1'b0;
            r_dz_pend <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
`ifdef MDU_DIV_EN
            r_a       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        case (i_op)
                            OP_MULT, OP_MULTU: begin
                                r_p       <= {{WIDTH{1'b0}}, w_b_mag};
                                r_d       <= w_a_mag;
                                r_neg_lo  <= w_sa ^ w_sb;
                                r_neg_hi  <= 1'b0;
                                r_is_div  <= 1'b0;
                                r_dz_pend <= 1'b0;
                                r_dz      <= 1'b0;
                                r_cnt     <= '0;
                                r_busy    <= 1'b1;
                                r_state   <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_p       <= {{WIDTH{1'b0}}, w_a_mag};
                                r_d       <= w_b_mag;
                                r_neg_lo  <= w_sa ^ w_sb;
                                r_neg_hi  <= w_sa;
                                r_is_div  <= 1'b1;
                                r_dz      <= 1'b0;
                                r_cnt     <= '0;
                                r_busy    <= 1'b1;
`ifdef MDU_DIV_EN
                                r_a       <= i_a;
                                if (i_b == '0) begin
                                    r_dz_pend <= 1'b1;
                                    r_state   <= S_FIX;
                                end else begin
                                    r_dz_pend <= 1'b0;
                                    r_state   <= S_DIV;
                                end
`else
                                r_dz_pend <= 1'b1;
                                r_state   <= S_FIX;
`endif
                            end
                            OP_MTHI: r_hi <= i_a;
                            OP_MTLO: r_lo <= i_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    r_p   <= w_iter;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Results commit here so they are visible during the DONE pulse.
                    if (r_dz_pend) begin
                        r_dz <= 1'b1;
`ifdef MDU_DIV_EN
                        r_hi <= r_a;
                        r_lo <= '1;
`endif
                    end else if (r_is_div) begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_dz   = r_dz;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: multiply, divide (or disabled-divider behaviour), MT ops, ignored starts, reset abort.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_dz;

    int n_pass;
    int n_fail;
    int n_tot;
    int cyc;
    int nbusy;
    int ndone;

    mdu_ctrl #(.WIDTH(32)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_hi    (o_hi),
        .o_lo    (o_lo),
        .o_dz    (o_dz)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the following rising edge is "edge 0".
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        i_start = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(posedge i_clk);
        #1 i_start = 1'b0;
    endtask

    // Returns the cycle number of the done pulse (0 on timeout) and cycles busy was seen.
    // At cycle inj a start (MTLO 0xAA) is presented for one cycle.
    task automatic wait_done(input int inj, output int c, output int nb);
        c  = 0;
        nb = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge i_clk);
            if (i == inj) begin
                i_start = 1'b1;
                i_op    = OP_MTLO;
                i_a     = 32'hAA;
            end else if (i == inj + 1) begin
                i_start = 1'b0;
            end
            if (o_busy) nb++;
            if (o_done) begin
                c = i;
                break;
            end
        end
        i_start = 1'b0;
        @(negedge i_clk);
    endtask

    initial begin
        n_pass  = 0;
        n_fail  = 0;
        n_tot   = 0;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_op    = 3'd0;
        i_a     = '0;
        i_b     = '0;
        repeat (2) @(negedge i_clk);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_done", {31'b0, o_done}, 32'd0);
        chk("rst_dz",   {31'b0, o_dz},   32'd0);
        chk("rst_hi",   o_hi, 32'd0);
        chk("rst_lo",   o_lo, 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        start_op(OP_MULTU, 32'h10, 32'h4);
        wait_done(0, cyc, nbusy);
        chk("multu_small_cyc",   cyc,   32'd34);
        chk("multu_small_nbusy", nbusy, 32'd34);
        chk("multu_small_hi",    o_hi,  32'h0);
        chk("multu_small_lo",    o_lo,  32'h40);
        chk("multu_small_idle",  {31'b0, o_busy}, 32'd0);

        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, cyc, nbusy);
        chk("multu_max_hi", o_hi, 32'hFFFFFFFE);
        chk("multu_max_lo", o_lo, 32'h00000001);

        start_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, cyc, nbusy);
        chk("mult_m1_hi", o_hi, 32'h0);
        chk("mult_m1_lo", o_lo, 32'h1);

`ifdef MDU_DIV_EN
        start_op(OP_DIV, 32'd16, 32'd3);
        wait_done(0, cyc, nbusy);
        chk("div_16_3_cyc", cyc,  32'd34);
        chk("div_16_3_lo",  o_lo, 32'd5);
        chk("div_16_3_hi",  o_hi, 32'd1);
        chk("div_16_3_dz",  {31'b0, o_dz}, 32'd0);

        start_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(0, cyc, nbusy);
        chk("div_m7_2_lo", o_lo, 32'hFFFFFFFD);
        chk("div_m7_2_hi", o_hi, 32'hFFFFFFFF);

        start_op(OP_DIVU, 32'hFFFFFFFF, 32'd1);
        wait_done(0, cyc, nbusy);
        chk("divu_max_1_lo", o_lo, 32'hFFFFFFFF);
        chk("divu_max_1_hi", o_hi, 32'h0);

        start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(0, cyc, nbusy);
        chk("div_ovf_lo", o_lo, 32'h80000000);
        chk("div_ovf_hi", o_hi, 32'h0);
        chk("div_ovf_dz", {31'b0, o_dz}, 32'd0);

        start_op(OP_DIV, 32'h12345678, 32'h0);
        wait_done(0, cyc, nbusy);
        chk("div_zero_cyc", cyc,  32'd2);
        chk("div_zero_hi",  o_hi, 32'h12345678);
        chk("div_zero_lo",  o_lo, 32'hFFFFFFFF);
        chk("div_zero_dz",  {31'b0, o_dz}, 32'd1);
`else
        start_op(OP_DIV, 32'h12345678, 32'h0);
        wait_done(0, cyc, nbusy);
        chk("div_off_cyc", cyc,  32'd2);
        chk("div_off_hi",  o_hi, 32'h0);
        chk("div_off_lo",  o_lo, 32'h1);
        chk("div_off_dz",  {31'b0, o_dz}, 32'd1);

        start_op(OP_DIVU, 32'd16, 32'd3);
        wait_done(0, cyc, nbusy);
        chk("divu_off_cyc", cyc,  32'd2);
        chk("divu_off_lo",  o_lo, 32'h1);
`endif

        start_op(OP_MULT, 32'd2, 32'd3);
        wait_done(0, cyc, nbusy);
        chk("mult_2_3_dz", {31'b0, o_dz}, 32'd0);
        chk("mult_2_3_lo", o_lo, 32'd6);
        chk("mult_2_3_hi", o_hi, 32'd0);

        start_op(OP_MULT, 32'd7, 32'hFFFFFFFD);
        wait_done(5, cyc, nbusy);
        chk("mult_ign_cyc", cyc,  32'd34);
        chk("mult_ign_lo",  o_lo, 32'hFFFFFFEB);
        chk("mult_ign_hi",  o_hi, 32'hFFFFFFFF);

`ifdef MDU_DIV_EN
        start_op(OP_DIVU, 32'h1000, 32'd7);
`else
        start_op(OP_MULTU, 32'h1000, 32'd7);
`endif
        repeat (10) @(negedge i_clk);
        chk("abort_busy_pre", {31'b0, o_busy}, 32'd1);
        i_rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, o_busy}, 32'd0);
        chk("abort_hi",   o_hi, 32'd0);
        chk("abort_lo",   o_lo, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_done) ndone++;
        end
        chk("abort_no_done", ndone, 32'd0);
        chk("abort_lo_hold", o_lo,  32'd0);

        i_start = 1'b1;
        i_op    = OP_MTHI;
        i_a     = 32'hDEADBEEF;
        @(posedge i_clk);
        #1;
        i_op    = OP_MTLO;
        i_a     = 32'h1;
        chk("mthi_busy", {31'b0, o_busy}, 32'd0);
        @(posedge i_clk);
        #1 i_start = 1'b0;
        @(negedge i_clk);
        chk("mt_hi",   o_hi, 32'hDEADBEEF);
        chk("mt_lo",   o_lo, 32'h1);
        chk("mt_busy", {31'b0, o_busy}, 32'd0);

        start_op(OP_MULTU, 32'd3, 32'd5);
        wait_done(0, cyc, nbusy);
        chk("post_rst_cyc", cyc,  32'd34);
        chk("post_rst_lo",  o_lo, 32'd15);
        chk("post_rst_hi",  o_hi, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; all widths below are in terms of WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request strobe, sampled only in IDLE.
REQ-005 op  input  3  operation code, sampled with start.
REQ-006 a  input  WIDTH  first operand (multiplicand/dividend/MTHI-MTLO source), sampled with start.
REQ-007 b  input  WIDTH  second operand (multiplier/divisor), sampled with start.
REQ-008 busy  output  1  high in every state except IDLE; the pipeline stalls HI/LO consumers while high.
REQ-009 done  output  1  one-cycle pulse when a MULT/DIV result is committed.
REQ-010 hi  output  WIDTH  HI register (product high half / remainder).
REQ-011 lo  output  WIDTH  LO register (product low half / quotient).
REQ-012 dz  output  1  sticky divide-by-zero flag of the last division; cleared by next accepted MULT/DIV.

Function
REQ-013 States IDLE, MUL, DIV, FIX, DONE; encoding is implementation choice.
REQ-014 Op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6-7 are ignored (no state change).
REQ-015 IDLE + start + MULT/MULTU -> MUL; DIV/DIVU -> DIV; MTHI/MTLO write a into hi/lo at that edge, stay IDLE, busy never rises.
REQ-016 MUL/DIV run exactly WIDTH iterations (radix-2 shift-add multiply, restoring divide) on operand magnitudes, then -> FIX.
REQ-017 FIX applies sign correction for signed ops (product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign), then -> DONE.
REQ-018 DONE: hi/lo updated at the edge entering DONE, done=1 for that one cycle, -> IDLE next edge.
REQ-019 Latency: start accepted at edge 0 -> done high in cycle WIDTH+2 (34 for WIDTH=32); next start accepted in the cycle after done.
REQ-020 start while busy is ignored; no queuing; hi/lo unchanged until the active operation completes.
REQ-021 Divide by zero: DIV state skipped, -> DONE on the edge after acceptance; hi=a, lo=all ones, dz=1.
REQ-022 Signed DIV of most-negative by -1: lo=most-negative, hi=0, dz=0.
REQ-023 hi/lo hold their value in all other cycles; MUL/DIV intermediates live in internal registers only.

Reset
REQ-024 rst asserted: state=IDLE, hi=0, lo=0, busy=0, done=0, dz=0, iteration counter=0, immediately and independent of clk.
REQ-025 rst mid-operation aborts it; no partial result reaches hi/lo; first start after release behaves as from power-up.

Configuration
REQ-026 Macro MDU_DIV_EN: defined -> division per REQ-016..REQ-022.
REQ-027 MDU_DIV_EN undefined -> no divider logic; DIV/DIVU accepted, -> DONE next edge with hi/lo unchanged, dz=1, done pulsed.

Structure
REQ-028 Shared package holds op-code constants, state enumeration and WIDTH default.
REQ-029 One sub-module mdu_iter: one combinational multiply/divide iteration step (partial value, operand, mode -> next partial value); the FSM, counter and HI/LO stay in mdu_ctrl.

Verification
REQ-030 MULTU a=0x10, b=0x4 -> done at cycle 34, hi=0x00000000, lo=0x00000040, busy high cycles 1-34.
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT same operands -> hi=0, lo=1.
REQ-032 DIV 16/3 -> lo=5, hi=1; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
REQ-033 DIV a=0x12345678, b=0 -> done on 2nd cycle, hi=0x12345678, lo=0xFFFFFFFF, dz=1; then MULT 2x3 -> dz=0, lo=6.
REQ-034 MULT started, second start (MTLO 0xAA) at cycle 5 ignored, lo!=0xAA after done; rst at cycle 10 of a DIV -> busy=0, hi=lo=0 immediately, no done pulse.
REQ-035 MTHI 0xDEADBEEF then MTLO 0x1 in consecutive cycles -> hi=0xDEADBEEF, lo=0x1, busy stays 0.
